// File: rtl/mem_resp_model_if.sv
// Memory request/response bus between a requester and the memory response model.
// Stall length and error injection travel with the request fields.
interface mem_resp_model_if;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [7:0]  mem_strb;
    logic [63:0] mem_wdata;
    logic [3:0]  stall_len;
    logic        err_inject;
    logic        mem_gnt;
    logic        mem_err;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wen,
        output mem_strb,
        output mem_wdata,
        output stall_len,
        output err_inject,
        input  mem_gnt,
        input  mem_err,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wen,
        input  mem_strb,
        input  mem_wdata,
        input  stall_len,
        input  err_inject,
        output mem_gnt,
        output mem_err,
        output mem_rdata
    );
endinterface

// File: rtl/mem_resp_model.sv
// Behavioural memory slave with programmable grant stall, address-range bus errors
// and error injection; responses appear the cycle after a grant.
module mem_resp_model #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [63:0] ERR_BASE  = 64'hFFFF_0000_0000_0000
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    mem_resp_model_if.slave   bus
);

    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    stall_cnt;
    logic                proto_violation;
    logic                resp_err;
    logic [DATA_W-1:0]   resp_rdata;
    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic [60:0]         word_addr;
    logic [IDX_W-1:0]    word_idx;
    logic                err_addr_c;
    logic                grant_c;
    logic                resp_err_c;
    logic                unused_bits;

    assign word_addr  = bus.mem_addr[63:3];
    assign word_idx   = word_addr[IDX_W-1:0];
    assign err_addr_c = (bus.mem_addr >= ERR_BASE) || (word_addr >= 61'(MEM_DEPTH));
    assign grant_c    = (state == ST_GRANT) && bus.mem_req;
    assign resp_err_c = bus.err_inject || err_addr_c;

    // Grant is a qualified decode of the GRANT state so a dropped request is never granted.
    assign bus.mem_gnt   = grant_c;
    assign bus.mem_err   = resp_err;
    assign bus.mem_rdata = resp_rdata;

    // Byte offset is ignored; the violation flag is for debug visibility only.
    assign unused_bits = ^{bus.mem_addr[2:0], proto_violation};

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state           <= ST_IDLE;
            stall_cnt       <= '0;
            proto_violation <= 1'b0;
            resp_err        <= 1'b0;
            resp_rdata      <= '0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Response fields live for exactly one cycle.
            resp_err   <= 1'b0;
            resp_rdata <= '0;

            case (state)
                ST_IDLE: begin
                    if (bus.mem_req) begin
                        stall_cnt <= bus.stall_len;
                        state     <= (bus.stall_len == '0) ? ST_GRANT : ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (!bus.mem_req) begin
                        state           <= ST_IDLE;
                        stall_cnt       <= '0;
                        proto_violation <= 1'b1;
                    end else if (stall_cnt == CNT_W'(1)) begin
                        stall_cnt <= '0;
                        state     <= ST_GRANT;
                    end else begin
                        stall_cnt <= stall_cnt - CNT_W'(1);
                    end
                end

                ST_GRANT: begin
                    state     <= ST_IDLE;
                    stall_cnt <= '0;
                    if (!bus.mem_req) begin
                        proto_violation <= 1'b1;
                    end else begin
                        resp_err <= resp_err_c;
                        if (!resp_err_c && !bus.mem_wen) begin
                            resp_rdata <= mem[word_idx];
                        end
                        if (!resp_err_c && bus.mem_wen) begin
                            for (int b = 0; b < int'(STRB_W); b++) begin
                                if (bus.mem_strb[b]) begin
                                    mem[word_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                                end
                            end
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    stall_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_resp_model.md
MEM_RESP_MODEL -- requirements
Module: mem_resp_model

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning the number of 64-bit backing words.
REQ-002 The block SHALL have parameter ERR_BASE, default 64'hFFFF_0000_0000_0000, meaning the first byte address that always returns a bus error.
REQ-003 The block SHALL have the following ports:
- g_clk  input  1  global clock.
- g_resetn  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- mem_req  input  1  request valid, held by the requester until granted.
- mem_addr  input  64  byte address; bits [2:0] ignored.
- mem_wen  input  1  1 = write, 0 = read.
- mem_strb  input  8  write byte strobe.
- mem_wdata  input  64  write data.
- mem_gnt  output  1  request accepted this cycle.
- mem_err  output  1  response error, valid the cycle after a grant.
- mem_rdata  output  64  read data, valid the cycle after a grant.
- stall_len  input  4  wait cycles inserted before a grant, sampled when a new request arrives.
- err_inject  input  1  force an error on the request granted this cycle.

Function
REQ-004 The block SHALL implement a state machine with states IDLE, WAIT and GRANT.
REQ-005 In IDLE with mem_req=1, the block SHALL capture stall_len into a down-counter.
- If stall_len=0, it SHALL enter GRANT.
- Otherwise it SHALL enter WAIT.
REQ-006 In WAIT, the counter SHALL decrement each cycle while mem_req=1, and the block SHALL enter GRANT when the counter reaches 0.
REQ-007 mem_gnt SHALL be 1 only in GRANT while mem_req=1, and asserting it SHALL complete the request.
REQ-008 After GRANT, the block SHALL return to IDLE.
- A new request is therefore granted no earlier than 2 cycles after the previous grant.
- Minimum request-to-grant latency is 1 cycle for stall_len=0.
REQ-009 If mem_req falls in WAIT or GRANT before a grant, the block SHALL return to IDLE, discard the counter and produce no response; the tolerated protocol violation is recorded in an internal flag only.
REQ-010 An error address is one where mem_addr >= ERR_BASE or mem_addr[63:3] >= MEM_DEPTH.
REQ-011 The response cycle is the cycle after a grant, and its values SHALL be:
- mem_err = 1 if err_inject was 1 or the address was an error address at the grant; else 0.
- mem_rdata = the word at the granted address for a non-error read; else 64'h0.
REQ-012 In every cycle other than the response cycle, mem_err and mem_rdata SHALL be 0.
REQ-013 A non-error write SHALL update, at the grant edge, only the bytes of word mem_addr[63:3] whose mem_strb bit is 1.
REQ-014 A write with mem_err=1 SHALL leave memory unchanged.
REQ-015 A read granted at the edge after a write SHALL return the updated data.
REQ-016 Reads SHALL never modify memory.
REQ-017 stall_len changes after capture SHALL have no effect on the current request.
REQ-018 A write with mem_strb=0 SHALL complete normally with no memory change and mem_err=0 unless it targets an error address.

Reset
REQ-019 While g_resetn=0 at a rising edge, the block SHALL set state=IDLE, counter=0, mem_gnt=0, mem_err=0 and mem_rdata=0.
REQ-020 While g_resetn=0 at a rising edge, the block SHALL clear all backing words to 0.
REQ-021 Reset asserted in WAIT or GRANT SHALL abort the request with no grant and no response.
REQ-022 Reset asserted in the response cycle SHALL force mem_err and mem_rdata to 0 on the next cycle.
REQ-023 The first request after reset release SHALL be treated as new, with stall_len re-sampled.

Verification
REQ-024 Scenario 1: after reset, read addr 0x10 with stall_len=0 -> mem_gnt=1 one cycle after req; next cycle mem_rdata=0, mem_err=0.
REQ-025 Scenario 2: write addr 0x18, strb=8'h0F, wdata=64'h1122334455667788, stall_len=3 -> mem_gnt after 4 cycles of req; a read of 0x18 then returns 64'h0000000055667788.
REQ-026 Scenario 3: read addr MEM_DEPTH*8 -> response mem_err=1, mem_rdata=0; a write to the same address leaves memory unchanged.
REQ-027 Scenario 4: err_inject=1 on a write to 0x8 -> mem_err=1 and word 1 still 0; a read with err_inject=0 gives mem_err=0.
REQ-028 Scenario 5: with stall_len=5, drop req after 2 cycles -> no mem_gnt and no response; the next request re-samples stall_len and is granted correctly.
REQ-029 Scenario 6: assert g_resetn=0 in WAIT after writing 0x20 -> no grant; after release, a read of 0x20 returns 0.
